// File: rtl/retire_rat_if.sv
// retire_rat_if: commit, free-list and rename-table signals of the retirement RAT
interface retire_rat_if #(
  parameter int PHYS_REG_BITS = 6,
  parameter int RELQ_DEPTH    = 4
);
  logic                          commit_valid;
  logic                          commit_ready;
  logic [4:0]                    commit_rd;
  logic [PHYS_REG_BITS-1:0]      commit_pd;
  logic                          commit_regf_we;
  logic                          commit_flush;
  logic                          free_valid;
  logic                          free_ready;
  logic [PHYS_REG_BITS-1:0]      free_pd;
  logic [31:0][PHYS_REG_BITS-1:0] rrat;
  logic                          global_branch_signal;
  logic [$clog2(RELQ_DEPTH+1)-1:0] relq_count;
  modport master (
    output commit_valid, commit_rd, commit_pd, commit_regf_we, commit_flush, free_ready,
    input  commit_ready, free_valid, free_pd, rrat, global_branch_signal, relq_count
  );
  modport slave (
    input  commit_valid, commit_rd, commit_pd, commit_regf_we, commit_flush, free_ready,
    output commit_ready, free_valid, free_pd, rrat, global_branch_signal, relq_count
  );
endinterface

// File: rtl/retire_rat.sv
// retire_rat: committed arch->phys map with a release FIFO returning displaced registers
module retire_rat #(
  parameter int PHYS_REG_BITS = 6,
  parameter int RELQ_DEPTH    = 4
) (
  input logic        clk,
  input logic        rst,
  retire_rat_if.slave bus
);
  localparam int AW = $clog2(RELQ_DEPTH);
  localparam int CW = $clog2(RELQ_DEPTH + 1);
  logic [31:0][PHYS_REG_BITS-1:0]         r_rrat;
  logic [RELQ_DEPTH-1:0][PHYS_REG_BITS-1:0] r_q;
  logic [AW-1:0]            r_wp, r_rp;
  logic [CW-1:0]            r_cnt;
  logic                     r_gbs;
  logic [PHYS_REG_BITS-1:0] r_free_pd;
  logic                     w_acc, w_push, w_pop;
  logic [PHYS_REG_BITS-1:0] w_old;
  logic [AW-1:0]            w_rp_n;
  logic [CW-1:0]            w_cnt_pop, w_cnt_n;
  assign bus.commit_ready         = (r_cnt < CW'(RELQ_DEPTH)) && !r_gbs;
  assign bus.free_valid           = r_cnt != '0;
  assign bus.free_pd              = r_free_pd;
  assign bus.rrat                 = r_rrat;
  assign bus.global_branch_signal = r_gbs;
  assign bus.relq_count           = r_cnt;
  always_comb begin
    w_acc     = bus.commit_valid && bus.commit_ready;
    w_old     = r_rrat[bus.commit_rd];
    w_push    = w_acc && bus.commit_regf_we && (bus.commit_rd != 5'd0) && (bus.commit_pd != w_old);
    w_pop     = (r_cnt != '0) && bus.free_ready;
    w_rp_n    = r_rp + AW'(w_pop);
    w_cnt_pop = r_cnt - CW'(w_pop);
    w_cnt_n   = w_cnt_pop + CW'(w_push);
  end
  // free_pd is the registered next head; an entry pushed into an emptying queue becomes head directly
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) r_rrat[i] <= PHYS_REG_BITS'(i);
      r_q       <= '0;
      r_wp      <= '0;
      r_rp      <= '0;
      r_cnt     <= '0;
      r_gbs     <= 1'b0;
      r_free_pd <= '0;
    end else begin
      if (w_push) begin
        r_rrat[bus.commit_rd] <= bus.commit_pd;
        r_q[r_wp]             <= w_old;
        r_wp                  <= r_wp + AW'(1);
      end
      r_rp      <= w_rp_n;
      r_cnt     <= w_cnt_n;
      r_gbs     <= w_acc && bus.commit_flush;
      r_free_pd <= (w_cnt_n == '0) ? '0 : (w_cnt_pop == '0) ? w_old : r_q[w_rp_n];
    end
  end
endmodule

// File: tb/tb_retire_rat.sv
// tb_retire_rat: scenario tasks plus a scoreboard of expected freed registers
module tb_retire_rat;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  retire_rat_if #(.PHYS_REG_BITS(6), .RELQ_DEPTH(4)) bus ();
  retire_rat #(.PHYS_REG_BITS(6), .RELQ_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_vec = 0;
  int n_err = 0;
  logic [5:0] exp_q[$];
  logic [31:0][5:0] m_rrat;
  bit mon_on = 1'b0;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rrat[i] = 6'(i);
    exp_q.delete();
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic [5:0] pd, input logic we, input logic fl);
    bus.commit_valid = v;
    bus.commit_rd = rd;
    bus.commit_pd = pd;
    bus.commit_regf_we = we;
    bus.commit_flush = fl;
  endtask

  // inputs change at negedge; the model samples them 2 time units later, well before posedge
  always @(negedge clk) begin
    #2;
    if (mon_on) begin
      n_vec++;
      if (bus.rrat !== m_rrat) begin
        n_err++;
        $display("FAIL rrat_track got %h want %h", bus.rrat, m_rrat);
      end
      n_vec++;
      if (bus.relq_count !== 3'(exp_q.size())) begin
        n_err++;
        $display("FAIL relq_count_track got %0d want %0d", bus.relq_count, exp_q.size());
      end
      if (!rst) model_reset();
      else begin
        if (bus.free_valid && bus.free_ready) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL free_pop got %0d want no entry", bus.free_pd);
          end else begin
            logic [5:0] e;
            e = exp_q.pop_front();
            if (bus.free_pd !== e) begin
              n_err++;
              $display("FAIL free_pd_order got %0d want %0d", bus.free_pd, e);
            end
          end
        end
        if (bus.commit_valid && bus.commit_ready && bus.commit_regf_we &&
            bus.commit_rd != 5'd0 && m_rrat[bus.commit_rd] != bus.commit_pd) begin
          exp_q.push_back(m_rrat[bus.commit_rd]);
          m_rrat[bus.commit_rd] = bus.commit_pd;
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    bus.free_ready = 1'b0;
    repeat (3) @(negedge clk);
    mon_on = 1'b1;
    n_vec++; if (bus.rrat[5] !== 6'd5) begin n_err++; $display("FAIL reset_rrat5 got %0d want 5", bus.rrat[5]); end
    n_vec++; if (bus.rrat[31] !== 6'd31) begin n_err++; $display("FAIL reset_rrat31 got %0d want 31", bus.rrat[31]); end
    n_vec++; if (bus.free_valid !== 1'b0) begin n_err++; $display("FAIL reset_free_valid got %b want 0", bus.free_valid); end
    n_vec++; if (bus.free_pd !== 6'd0) begin n_err++; $display("FAIL reset_free_pd got %0d want 0", bus.free_pd); end
    n_vec++; if (bus.relq_count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", bus.relq_count); end
    n_vec++; if (bus.commit_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", bus.commit_ready); end
    n_vec++; if (bus.global_branch_signal !== 1'b0) begin n_err++; $display("FAIL reset_gbs got %b want 0", bus.global_branch_signal); end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    bus.free_ready = 1'b1;
    drive(1, 5, 40, 1, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    n_vec++; if (bus.rrat[5] !== 6'd40) begin n_err++; $display("FAIL basic_rrat5 got %0d want 40", bus.rrat[5]); end
    n_vec++; if (bus.free_valid !== 1'b1) begin n_err++; $display("FAIL basic_free_valid got %b want 1", bus.free_valid); end
    n_vec++; if (bus.free_pd !== 6'd5) begin n_err++; $display("FAIL basic_free_pd got %0d want 5", bus.free_pd); end
    @(negedge clk);
    n_vec++; if (bus.free_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain got %b want 0", bus.free_valid); end
  endtask

  task automatic test_nochange();
    drive(1, 0, 33, 1, 0);
    @(negedge clk);
    drive(1, 7, 34, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    n_vec++; if (bus.rrat[0] !== 6'd0) begin n_err++; $display("FAIL nochange_rrat0 got %0d want 0", bus.rrat[0]); end
    n_vec++; if (bus.relq_count !== 3'd0) begin n_err++; $display("FAIL nochange_count got %0d want 0", bus.relq_count); end
    @(negedge clk);
    n_vec++; if (bus.rrat[7] !== 6'd7) begin n_err++; $display("FAIL nochange_rrat7 got %0d want 7", bus.rrat[7]); end
    n_vec++; if (bus.free_valid !== 1'b0) begin n_err++; $display("FAIL nochange_free_valid got %b want 0", bus.free_valid); end
  endtask

  task automatic test_full();
    bus.free_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1, 5'(i), 6'(40 + i), 1, 0);
      @(negedge clk);
    end
    drive(1, 6, 46, 1, 0);
    n_vec++; if (bus.relq_count !== 3'd4) begin n_err++; $display("FAIL full_count got %0d want 4", bus.relq_count); end
    n_vec++; if (bus.commit_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got %b want 0", bus.commit_ready); end
    n_vec++; if (bus.free_pd !== 6'd1) begin n_err++; $display("FAIL full_head got %0d want 1", bus.free_pd); end
    repeat (2) @(negedge clk);
    n_vec++; if (bus.rrat[6] !== 6'd6) begin n_err++; $display("FAIL full_blocked_rrat6 got %0d want 6", bus.rrat[6]); end
    n_vec++; if (bus.relq_count !== 3'd4) begin n_err++; $display("FAIL full_hold_count got %0d want 4", bus.relq_count); end
    drive(0, 0, 0, 0, 0);
    bus.free_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (bus.relq_count !== 3'd3) begin n_err++; $display("FAIL full_pop_count got %0d want 3", bus.relq_count); end
    n_vec++; if (bus.commit_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_back got %b want 1", bus.commit_ready); end
    n_vec++; if (bus.free_pd !== 6'd2) begin n_err++; $display("FAIL full_next_head got %0d want 2", bus.free_pd); end
  endtask

  task automatic test_back_to_back();
    drive(1, 9, 50, 1, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    n_vec++; if (bus.relq_count !== 3'd3) begin n_err++; $display("FAIL b2b_count got %0d want 3", bus.relq_count); end
    n_vec++; if (bus.free_pd !== 6'd3) begin n_err++; $display("FAIL b2b_head got %0d want 3", bus.free_pd); end
    n_vec++; if (bus.rrat[9] !== 6'd50) begin n_err++; $display("FAIL b2b_rrat9 got %0d want 50", bus.rrat[9]); end
    @(negedge clk);
    n_vec++; if (bus.free_pd !== 6'd4) begin n_err++; $display("FAIL b2b_head2 got %0d want 4", bus.free_pd); end
    @(negedge clk);
    n_vec++; if (bus.free_pd !== 6'd9) begin n_err++; $display("FAIL b2b_last got %0d want 9", bus.free_pd); end
    @(negedge clk);
    n_vec++; if (bus.free_valid !== 1'b0) begin n_err++; $display("FAIL b2b_empty got %b want 0", bus.free_valid); end
  endtask

  task automatic test_flush();
    drive(1, 2, 45, 1, 1);
    @(negedge clk);
    drive(1, 3, 47, 1, 1);
    n_vec++; if (bus.global_branch_signal !== 1'b1) begin n_err++; $display("FAIL flush_pulse got %b want 1", bus.global_branch_signal); end
    n_vec++; if (bus.rrat[2] !== 6'd45) begin n_err++; $display("FAIL flush_rrat2 got %0d want 45", bus.rrat[2]); end
    n_vec++; if (bus.commit_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready got %b want 0", bus.commit_ready); end
    n_vec++; if (bus.free_pd !== 6'd42) begin n_err++; $display("FAIL flush_free_pd got %0d want 42", bus.free_pd); end
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    n_vec++; if (bus.global_branch_signal !== 1'b0) begin n_err++; $display("FAIL flush_pulse_end got %b want 0", bus.global_branch_signal); end
    n_vec++; if (bus.rrat[3] !== 6'd43) begin n_err++; $display("FAIL flush_blocked_rrat3 got %0d want 43", bus.rrat[3]); end
    n_vec++; if (bus.commit_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready_back got %b want 1", bus.commit_ready); end
    @(negedge clk);
    n_vec++; if (bus.global_branch_signal !== 1'b0) begin n_err++; $display("FAIL flush_ignored got %b want 0", bus.global_branch_signal); end
  endtask

  task automatic test_reset_mid();
    bus.free_ready = 1'b0;
    drive(1, 10, 51, 1, 0);
    @(negedge clk);
    n_vec++; if (bus.relq_count !== 3'd1) begin n_err++; $display("FAIL mid_count got %0d want 1", bus.relq_count); end
    drive(1, 11, 52, 1, 1);
    rst = 1'b0;
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    n_vec++; if (bus.global_branch_signal !== 1'b0) begin n_err++; $display("FAIL mid_gbs got %b want 0", bus.global_branch_signal); end
    n_vec++; if (bus.relq_count !== 3'd0) begin n_err++; $display("FAIL mid_count_clr got %0d want 0", bus.relq_count); end
    n_vec++; if (bus.free_valid !== 1'b0) begin n_err++; $display("FAIL mid_free_valid got %b want 0", bus.free_valid); end
    n_vec++; if (bus.free_pd !== 6'd0) begin n_err++; $display("FAIL mid_free_pd got %0d want 0", bus.free_pd); end
    n_vec++; if (bus.rrat[11] !== 6'd11) begin n_err++; $display("FAIL mid_rrat11 got %0d want 11", bus.rrat[11]); end
    n_vec++; if (bus.rrat[5] !== 6'd5) begin n_err++; $display("FAIL mid_rrat5 got %0d want 5", bus.rrat[5]); end
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if (bus.commit_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready got %b want 1", bus.commit_ready); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_nochange();
    test_full();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/retire_rat.md
Name: retire_rat

Overview:
- Retirement-side rename table: the architectural (committed) arch→phys register map.
- Consumes in-order commits from the ROB and updates the committed mapping.
- Returns each displaced physical register to the free list through a small release queue.
- Drives the `rrat` snapshot and the `global_branch_signal` flush pulse back to the speculative rename table at dispatch.

Parameters:
- PHYS_REG_BITS, 6, width of a physical register index.
- RELQ_DEPTH, 4, entries in the release queue toward the free list (power of two, ≥2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low (asserted when 0)
- commit_valid  in  1  ROB head is retiring this cycle
- commit_ready  out  1  retire_rat can accept a commit
- commit_rd  in  5  architectural destination of the retiring instruction
- commit_pd  in  PHYS_REG_BITS  physical destination of the retiring instruction
- commit_regf_we  in  1  retiring instruction writes a register
- commit_flush  in  1  retiring instruction is a mispredicted branch
- free_valid  out  1  release-queue head holds a freed physical register
- free_ready  in  1  free list accepts free_pd
- free_pd  out  PHYS_REG_BITS  physical register being returned
- rrat  out  32 x PHYS_REG_BITS  committed mapping, registered
- global_branch_signal  out  1  one-cycle flush pulse to the front end and rename table
- relq_count  out  $clog2(RELQ_DEPTH+1)  release-queue occupancy

Behaviour:
- Reset (rst==0 at posedge):
  - rrat[i]=i for i=0..31.
  - Queue empty, relq_count=0, free_valid=0, free_pd=0, global_branch_signal=0.
  - Reset mid-operation discards queued entries and any pending flush pulse.
- commit_ready = (relq_count < RELQ_DEPTH) && !global_branch_signal. It is combinational and does not depend on commit_valid.
- A commit is accepted on a posedge where commit_valid && commit_ready.
- Accepted commit with commit_regf_we=1, commit_rd!=0, and commit_pd!=rrat[commit_rd]:
  - rrat[commit_rd] <= commit_pd.
  - The old rrat[commit_rd] is pushed onto the release queue tail.
- Accepted commit with commit_regf_we=0, commit_rd==0, or commit_pd==rrat[commit_rd]: no rrat change, no push.
- rrat[0] stays 0 permanently.
- Release queue is a FIFO:
  - free_valid = (relq_count!=0); free_pd = head entry, registered, no combinational bypass.
  - A pushed entry becomes visible on free_pd the cycle after acceptance.
  - Pop occurs on free_valid && free_ready.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Full (count==RELQ_DEPTH) deasserts commit_ready even if a pop happens that cycle.
  - Pointers wrap modulo RELQ_DEPTH.
- Flush:
  - An accepted commit with commit_flush=1 sets global_branch_signal=1 on the next cycle, for exactly one cycle.
  - In that cycle rrat already contains that commit's update, so the rename table copies a consistent map.
  - commit_ready=0 during the pulse.
  - The release queue is not cleared by a flush; its entries are truly free.
  - commit_flush is ignored when the commit is not accepted.
- Freeing of the speculative physical registers on flush is owned by the free list, not by this block.
- rrat changes only at an accepted commit or at reset.

Test Plan:
- Reset → rrat[5]=5, rrat[31]=31, free_valid=0, relq_count=0, commit_ready=1, global_branch_signal=0.
- Commit rd=5, pd=40, we=1 with free_ready=1:
  - next cycle rrat[5]=40, free_valid=1, free_pd=5;
  - cycle after, free_valid=0.
- Commit rd=0, pd=33, we=1; then commit rd=7, pd=34, we=0 → rrat unchanged, relq_count stays 0.
- free_ready=0; commit rd=1..4 → pd 41..44:
  - after 4 commits relq_count=4 and commit_ready=0;
  - a 5th commit_valid is not accepted;
  - raise free_ready → free_pd sequence 1,2,3,4 and commit_ready returns 1 once count<4.
- Count=3, free_ready=1, commit rd=9, pd=50 → count stays 3, FIFO order preserved, new entry 9 popped last.
- Commit rd=2, pd=45, flush=1:
  - next cycle global_branch_signal=1 and rrat[2]=45;
  - commit_ready=0 that cycle;
  - pulse low the following cycle.
- Assert rst=0 with queue non-empty and flush pending → all outputs return to reset values next cycle.
